// File: rtl/cpu_lsu.sv
// cpu_lsu: single-outstanding load/store unit bridging the pipeline to a request/ack data bus.
// Define CPU_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module cpu_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        lsu_write,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_signed,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic        lsu_misaligned,
    output logic        cpud_request,
    output logic [31:0] cpud_addr,
    output logic        cpud_write,
    output logic [3:0]  cpud_byte_enable,
    output logic [31:0] cpud_wdata,
    input  logic [31:0] cpud_rdata,
    input  logic        cpud_ack
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_n;
    logic [31:0] cnt;
    logic [1:0] sz, off, a_off;
    logic sg, accept, issue, trap, ack_hit, timeout;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic [31:0] fmt;
    logic busy_n, done_n, fault_n, mis_n, req_n, write_n;
    logic [31:0] rdata_n, addr_n, wdata_n;
    logic [3:0] be_n;
    assign accept = state == IDLE && lsu_valid;
`ifdef CPU_LSU_MISALIGN_TRAP_EN
    assign trap = accept && ((lsu_size == 2'b01 && lsu_addr[0]) || (lsu_size[1] && lsu_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif
    assign issue = accept && !trap;
    // ack wins over an expiring count in the same cycle
    assign ack_hit = state != IDLE && cpud_ack;
    assign timeout = state == WAIT && !cpud_ack && TIMEOUT_CYCLES != 0 && cnt + 32'd1 == 32'(TIMEOUT_CYCLES);
    // ignored low bits are dropped so the access proceeds aligned
    assign a_off = lsu_size[1] ? 2'b00 : lsu_size[0] ? {lsu_addr[1], 1'b0} : lsu_addr[1:0];
    assign byte_sel = cpud_rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? cpud_rdata[31:16] : cpud_rdata[15:0];
    assign fmt = sz[1] ? cpud_rdata
               : sz[0] ? {{16{sg & half_sel[15]}}, half_sel}
               : {{24{sg & byte_sel[7]}}, byte_sel};
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == WAIT ? cnt + 32'd1 : '0;
        end
    end
    always_comb begin
        state_n = state;
        if (issue) state_n = REQ;
        else if (ack_hit || timeout) state_n = IDLE;
        else if (state == REQ) state_n = WAIT;
    end
    always_comb begin
        done_n  = ack_hit || timeout || trap;
        fault_n = timeout;
        mis_n   = trap;
        busy_n  = state_n != IDLE;
        req_n   = state_n == REQ;
        rdata_n = ack_hit && !cpud_write ? fmt : done_n ? 32'd0 : lsu_rdata;
        addr_n  = issue ? {lsu_addr[31:2], 2'b00} : cpud_addr;
        write_n = issue ? lsu_write : cpud_write;
        be_n    = !issue ? cpud_byte_enable
                : lsu_size[1] ? 4'hF
                : lsu_size[0] ? (a_off[1] ? 4'hC : 4'h3)
                : 4'b0001 << a_off;
        wdata_n = !issue ? cpud_wdata
                : lsu_size[1] ? lsu_wdata
                : lsu_size[0] ? {2{lsu_wdata[15:0]}}
                : {4{lsu_wdata[7:0]}};
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsu_busy         <= 1'b0;
            lsu_done         <= 1'b0;
            lsu_fault        <= 1'b0;
            lsu_misaligned   <= 1'b0;
            lsu_rdata        <= '0;
            cpud_request     <= 1'b0;
            cpud_addr        <= '0;
            cpud_write       <= 1'b0;
            cpud_byte_enable <= '0;
            cpud_wdata       <= '0;
            sz               <= '0;
            sg               <= 1'b0;
            off              <= '0;
        end else begin
            lsu_busy         <= busy_n;
            lsu_done         <= done_n;
            lsu_fault        <= fault_n;
            lsu_misaligned   <= mis_n;
            lsu_rdata        <= rdata_n;
            cpud_request     <= req_n;
            cpud_addr        <= addr_n;
            cpud_write       <= write_n;
            cpud_byte_enable <= be_n;
            cpud_wdata       <= wdata_n;
            if (issue) begin
                sz  <= lsu_size;
                sg  <= lsu_signed;
                off <= a_off;
            end
        end
    end
endmodule

// File: tb/tb_cpu_lsu.sv
// tb_cpu_lsu: scoreboard bench for cpu_lsu with a scripted one-op-at-a-time bus responder.
module tb_cpu_lsu;
    localparam int TO = 4;
    logic clock = 1'b0, reset = 1'b0;
    logic lsu_valid = 1'b0, lsu_write = 1'b0, lsu_signed = 1'b0, cpud_ack = 1'b0;
    logic [1:0] lsu_size = 2'b00;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, cpud_rdata = '0;
    logic lsu_busy, lsu_done, lsu_fault, lsu_misaligned, cpud_request, cpud_write;
    logic [31:0] lsu_rdata, cpud_addr, cpud_wdata;
    logic [3:0] cpud_byte_enable;
    typedef struct {
        logic [31:0] rd;
        logic        f;
        logic        m;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic [31:0] last_rd = '0;

    cpu_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_write(lsu_write), .lsu_size(lsu_size),
        .lsu_signed(lsu_signed), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_fault(lsu_fault), .lsu_misaligned(lsu_misaligned),
        .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
        .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
        .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (lsu_done) begin
            if (sb.size() == 0) check("stray_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", lsu_rdata, e.rd);
                check("fault", {31'd0, lsu_fault}, {31'd0, e.f});
                check("misaligned", {31'd0, lsu_misaligned}, {31'd0, e.m});
            end
        end
    end

    // n = WAIT cycles before ack (0 = ack during REQ, -1 = never ack)
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] bus, input int n,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        logic [31:0] ea;
        ea = {a[31:2], 2'b00};
        lsu_valid = 1'b1; lsu_write = w; lsu_size = sz; lsu_signed = sg; lsu_addr = a; lsu_wdata = wd;
        sb.push_back('{rd: erd, f: n < 0, m: 1'b0});
        @(negedge clock);
        lsu_valid = 1'b0;
        check("req", {31'd0, cpud_request}, 32'd1);
        check("addr", cpud_addr, ea);
        check("be", {28'd0, cpud_byte_enable}, {28'd0, ebe});
        check("wdata", cpud_wdata, ewd);
        check("write", {31'd0, cpud_write}, {31'd0, w});
        check("busy", {31'd0, lsu_busy}, 32'd1);
        check("done_pulse", {31'd0, lsu_done}, 32'd0);
        check("rdata_hold", lsu_rdata, last_rd);
        cpud_rdata = bus;
        if (n == 0) cpud_ack = 1'b1;
        for (int i = 1; i <= (n < 0 ? TO : n); i++) begin
            @(negedge clock);
            lsu_valid = i == 1;
            lsu_addr = 32'h0000_0FFC;
            lsu_write = ~w;
            check("wait_busy", {31'd0, lsu_busy}, 32'd1);
            check("wait_req", {31'd0, cpud_request}, 32'd0);
            check("addr_hold", cpud_addr, ea);
            check("wait_done", {31'd0, lsu_done}, 32'd0);
            if (i == n) cpud_ack = 1'b1;
        end
        @(negedge clock);
        cpud_ack = 1'b0;
        lsu_valid = 1'b0;
        check("done", {31'd0, lsu_done}, 32'd1);
        last_rd = erd;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_busy", {31'd0, lsu_busy}, 32'd0);
        check("rst_done", {31'd0, lsu_done}, 32'd0);
        check("rst_req", {31'd0, cpud_request}, 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        check("rst_be", {28'd0, cpud_byte_enable}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        run_op(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'hF, 32'hDEADBEEF, 32'h0);
        run_op(0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234, 1, 4'h8, 32'h0, 32'hFFFFFF80);
        run_op(0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234, 1, 4'h8, 32'h0, 32'h00000080);
        run_op(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 1, 4'hC, 32'hABCDABCD, 32'h0);
        run_op(0, 2'b01, 1, 32'h202, 32'h0, 32'hABCDABCD, 1, 4'hC, 32'h0, 32'hFFFFABCD);
        run_op(1, 2'b00, 0, 32'h101, 32'h0000005A, 32'h0, 1, 4'h2, 32'h5A5A5A5A, 32'h0);
        run_op(0, 2'b01, 0, 32'h200, 32'h0, 32'h12348001, 1, 4'h3, 32'h0, 32'h00008001);
        run_op(0, 2'b11, 1, 32'h104, 32'h0, 32'h87654321, 2, 4'hF, 32'h0, 32'h87654321);
        run_op(0, 2'b00, 1, 32'h102, 32'h0, 32'h007F0000, 0, 4'h4, 32'h0, 32'h0000007F);
        run_op(0, 2'b10, 0, 32'h108, 32'h0, 32'hCAFEF00D, TO, 4'hF, 32'h0, 32'hCAFEF00D);
        run_op(0, 2'b10, 0, 32'h10C, 32'h0, 32'h55555555, -1, 4'hF, 32'h0, 32'h0);
        @(negedge clock);
        cpud_ack = 1'b1;
        @(negedge clock);
        cpud_ack = 1'b0;
        check("late_ack_done", {31'd0, lsu_done}, 32'd0);
        check("late_ack_busy", {31'd0, lsu_busy}, 32'd0);
`ifdef CPU_LSU_MISALIGN_TRAP_EN
        lsu_valid = 1'b1; lsu_write = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h101;
        sb.push_back('{rd: 32'h0, f: 1'b0, m: 1'b1});
        @(negedge clock);
        lsu_valid = 1'b0;
        check("mis_no_req", {31'd0, cpud_request}, 32'd0);
        check("mis_done", {31'd0, lsu_done}, 32'd1);
        check("mis_busy", {31'd0, lsu_busy}, 32'd0);
        last_rd = 32'h0;
`else
        run_op(0, 2'b10, 0, 32'h101, 32'h0, 32'h11223344, 1, 4'hF, 32'h0, 32'h11223344);
`endif
        lsu_valid = 1'b1; lsu_write = 1'b1; lsu_size = 2'b10; lsu_addr = 32'h300; lsu_wdata = 32'h1;
        @(negedge clock);
        lsu_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_wait_busy", {31'd0, lsu_busy}, 32'd0);
        check("rst_wait_req", {31'd0, cpud_request}, 32'd0);
        check("rst_wait_addr", cpud_addr, 32'd0);
        check("rst_wait_wdata", cpud_wdata, 32'd0);
        check("rst_wait_rdata", lsu_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        cpud_ack = 1'b1;
        @(negedge clock);
        cpud_ack = 1'b0;
        check("rst_ack_done", {31'd0, lsu_done}, 32'd0);
        check("rst_ack_busy", {31'd0, lsu_busy}, 32'd0);
        check("rst_ack_rdata", lsu_rdata, 32'd0);
        last_rd = 32'h0;
        run_op(0, 2'b00, 0, 32'h400, 32'h0, 32'h000000C3, 1, 4'h1, 32'h0, 32'h000000C3);
        repeat (3) @(negedge clock);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_lsu.md
CPU_LSU -- requirements
Module: cpu_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles to wait for cpud_ack before faulting; 0 disables the timeout.
REQ-002 SHALL have ports: clock  in  1  system clock (single clock domain, all logic on posedge).
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 lsu_valid  in  1  pipeline issues a load/store (single-cycle pulse); lsu_write  in  1  1=store, 0=load.
REQ-005 lsu_size  in  2  00=byte, 01=halfword, 10=word (11 treated as word); lsu_signed  in  1  sign-extend loads.
REQ-006 lsu_addr  in  32  byte address; lsu_wdata  in  32  store data, right-justified.
REQ-007 lsu_busy  out  1  op in flight; lsu_done  out  1  op complete (one-cycle pulse); lsu_rdata  out  32  formatted load result.
REQ-008 lsu_fault  out  1  bus timeout (pulses with lsu_done); lsu_misaligned  out  1  alignment trap (pulses with lsu_done).
REQ-009 cpud_request  out  1; cpud_addr  out  32; cpud_write  out  1; cpud_byte_enable  out  4; cpud_wdata  out  32; cpud_rdata  in  32; cpud_ack  in  1.

Function
REQ-010 SHALL implement states IDLE, REQ, WAIT; all outputs registered.
REQ-011 IDLE: lsu_valid accepted; next cycle state=REQ, cpud_request=1 for exactly one cycle, then WAIT.
REQ-012 lsu_busy SHALL be 1 in REQ and WAIT; lsu_valid while busy SHALL be ignored.
REQ-013 cpud_addr SHALL be {lsu_addr[31:2],2'b00}; cpud_addr/write/byte_enable/wdata SHALL hold stable from REQ until the ack cycle.
REQ-014 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?1100:0011; word -> 1111.
REQ-015 Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-016 Load: select byte/half at addr[1:0] from cpud_rdata, zero- or sign-extend per lsu_signed; word returned unmodified.
REQ-017 cpud_ack sampled in REQ or WAIT SHALL complete the op: next cycle lsu_done=1, lsu_rdata=result (0 for stores), state=IDLE.
REQ-018 Latency with a 1-cycle responder: lsu_valid at T -> cpud_request at T+1 -> cpud_ack at T+2 -> lsu_done at T+3.
REQ-019 cpud_ack in IDLE SHALL be ignored (late/stray acks).
REQ-020 Timeout: counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES with no ack, lsu_done=1, lsu_fault=1, lsu_rdata=0, state=IDLE.
REQ-021 Ack in the same cycle the count expires SHALL win (normal completion, no fault).
REQ-022 lsu_done, lsu_fault, lsu_misaligned SHALL be single-cycle pulses; lsu_rdata SHALL hold until the next lsu_done.
REQ-023 A new lsu_valid in the lsu_done cycle SHALL be accepted (back-to-back, one op per 3 cycles minimum).

Reset
REQ-024 reset low SHALL asynchronously force state=IDLE, counter=0, all outputs 0.
REQ-025 Reset during REQ/WAIT SHALL abandon the op; no lsu_done; a subsequent ack SHALL be ignored.

Configuration
REQ-026 Macro CPU_LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no bus request; next cycle lsu_done=1, lsu_misaligned=1, lsu_rdata=0, state stays IDLE.
REQ-027 Macro undefined: lsu_misaligned tied 0; ignored low address bits (addr[0] for half, addr[1:0] for word) SHALL be truncated and the access proceeds aligned.

Verification
REQ-028 Word store addr 0x100, data 0xDEADBEEF -> cpud_request T+1, addr 0x100, be 1111, wdata 0xDEADBEEF; ack T+2 -> lsu_done T+3, rdata 0.
REQ-029 Signed byte load addr 0x103, cpud_rdata 0x80FF1234 -> be 1000, lsu_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-030 Half store addr 0x202, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; signed half load of same -> 0xFFFFABCD.
REQ-031 TIMEOUT_CYCLES=4, no ack -> lsu_done+lsu_fault after 4 WAIT cycles, rdata 0; late ack in IDLE -> no lsu_done.
REQ-032 With CPU_LSU_MISALIGN_TRAP_EN: word load addr 0x101 -> no cpud_request, lsu_misaligned+lsu_done next cycle; without macro -> access to 0x100, be 1111.
REQ-033 Reset asserted in WAIT, ack next cycle after release -> no lsu_done, lsu_busy 0, all outputs 0.
